// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and hex decoder.
// Segment order is {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

    localparam logic [6:0] SEG_HEX_0 = 7'h3F;
    localparam logic [6:0] SEG_HEX_1 = 7'h06;
    localparam logic [6:0] SEG_HEX_2 = 7'h5B;
    localparam logic [6:0] SEG_HEX_3 = 7'h4F;
    localparam logic [6:0] SEG_HEX_4 = 7'h66;
    localparam logic [6:0] SEG_HEX_5 = 7'h6D;
    localparam logic [6:0] SEG_HEX_6 = 7'h7D;
    localparam logic [6:0] SEG_HEX_7 = 7'h07;
    localparam logic [6:0] SEG_HEX_8 = 7'h7F;
    localparam logic [6:0] SEG_HEX_9 = 7'h6F;
    localparam logic [6:0] SEG_HEX_A = 7'h77;
    localparam logic [6:0] SEG_HEX_B = 7'h7C;
    localparam logic [6:0] SEG_HEX_C = 7'h39;
    localparam logic [6:0] SEG_HEX_D = 7'h5E;
    localparam logic [6:0] SEG_HEX_E = 7'h79;
    localparam logic [6:0] SEG_HEX_F = 7'h71;
    localparam logic [6:0] SEG_OFF   = 7'h00;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = SEG_HEX_0;
            4'h1: seg = SEG_HEX_1;
            4'h2: seg = SEG_HEX_2;
            4'h3: seg = SEG_HEX_3;
            4'h4: seg = SEG_HEX_4;
            4'h5: seg = SEG_HEX_5;
            4'h6: seg = SEG_HEX_6;
            4'h7: seg = SEG_HEX_7;
            4'h8: seg = SEG_HEX_8;
            4'h9: seg = SEG_HEX_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            default: seg = SEG_HEX_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/edge_tick_sync.sv
// Three-flop synchroniser with a registered single-cycle rising-edge tick.
// Reusable by any consumer of the clock divider's square wave.
module edge_tick_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic tick
);

    logic       s1_q, s2_q, s3_q, tick_q;
    logic [1:0] fill_q;

    // For two edges after reset s3 loads from s1 alongside s2, so a level that is
    // already high at release refills s2 and s3 together and never looks like an edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            fill_q <= 2'b00;
            tick_q <= 1'b0;
        end else begin
            s1_q   <= d_async;
            s2_q   <= s1_q;
            s3_q   <= fill_q[1] ? s2_q : s1_q;
            fill_q <= {fill_q[0], 1'b1};
            tick_q <= s2_q & ~s3_q;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed common-anode hex display driven by divider ticks, with a per-frame
// snapshot of the value and optional leading-zero blanking.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter bit          ACTIVE_LOW_OUT = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_div,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_en,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp_out,
    output logic                    frame_tick
);

    localparam int unsigned IdxW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

    localparam logic [NUM_DIGITS-1:0] AnOff =
        ACTIVE_LOW_OUT ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [6:0] SegOffOut = ACTIVE_LOW_OUT ? ~SEG_OFF : SEG_OFF;
    localparam logic       DpOffOut  = ACTIVE_LOW_OUT;

    logic                    tick, wrap;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic                    frame_tick_q, frame_tick_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d, an_raw;
    logic [6:0]              seg_q, seg_d, seg_raw;
    logic                    dp_q, dp_d, dp_raw;
    logic                    upper_zero, blank;
    logic [3:0]              cur_nib;

    edge_tick_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .d_async (clk_div),
        .tick    (tick)
    );

    assign wrap = tick && (idx_q == LastIdx);

    always_comb begin
        idx_d        = idx_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        frame_tick_d = wrap;
        if (wrap) begin
            idx_d        = '0;
            shadow_val_d = value;
            shadow_dp_d  = dp_in;
        end else if (tick) begin
            idx_d = idx_q + 1'b1;
        end
    end

    // Active digit is blankable only if it and every digit to its left are bare zeros.
    always_comb begin
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((IdxW'(i) >= idx_q) &&
                ((shadow_val_q[4*i +: 4] != 4'h0) || shadow_dp_q[i])) begin
                upper_zero = 1'b0;
            end
        end
    end

    always_comb begin
        blank          = blank_en && (idx_q != '0) && upper_zero;
        cur_nib        = shadow_val_q[idx_q*4 +: 4];
        an_raw         = '0;
        an_raw[idx_q]  = 1'b1;
        seg_raw        = blank ? SEG_OFF : hex_to_seg(cur_nib);
        dp_raw         = blank ? 1'b0 : shadow_dp_q[idx_q];
        an_d           = ACTIVE_LOW_OUT ? ~an_raw : an_raw;
        seg_d          = ACTIVE_LOW_OUT ? ~seg_raw : seg_raw;
        dp_d           = ACTIVE_LOW_OUT ? ~dp_raw : dp_raw;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            frame_tick_q <= 1'b0;
            an_q         <= AnOff;
            seg_q        <= SegOffOut;
            dp_q         <= DpOffOut;
        end else begin
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            frame_tick_q <= frame_tick_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp_out     = dp_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: expected digit displays are queued by the
// stimulus and checked by a monitor whenever the active anode changes.
module tb_seg7_scan;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       frame;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk_div = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic        blank_en = 1'b0;
    logic [3:0]  an, an_h;
    logic [6:0]  seg, seg_h;
    logic        dp_out, dp_h, frame_tick, ft_h;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    seg7_scan #(.NUM_DIGITS(4), .ACTIVE_LOW_OUT(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_div    (clk_div),
        .value      (value),
        .dp_in      (dp_in),
        .blank_en   (blank_en),
        .an         (an),
        .seg        (seg),
        .dp_out     (dp_out),
        .frame_tick (frame_tick)
    );

    seg7_scan #(.NUM_DIGITS(4), .ACTIVE_LOW_OUT(1'b0)) dut_h (
        .clk        (clk),
        .rst        (rst),
        .clk_div    (clk_div),
        .value      (value),
        .dp_in      (dp_in),
        .blank_en   (blank_en),
        .an         (an_h),
        .seg        (seg_h),
        .dp_out     (dp_h),
        .frame_tick (ft_h)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, want);
        end
    endtask

    task automatic expect_disp(input logic [3:0] a, input logic [6:0] s, input logic d,
                               input logic f);
        exp_q.push_back(exp_t'({a, s, d, f}));
    endtask

    // One clk_div rising edge; the new digit is visible before the task returns.
    task automatic pulse();
        @(negedge clk);
        clk_div = 1'b1;
        repeat (2) @(negedge clk);
        clk_div = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic step(input logic [3:0] a, input logic [6:0] s, input logic d,
                        input logic f);
        expect_disp(a, s, d, f);
        pulse();
    endtask

    initial begin : monitor
        logic [3:0] an_prev;
        int         frames;
        exp_t       e;
        an_prev = 4'hF;
        frames  = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                frames = 0;
            end else begin
                if (frame_tick) frames++;
                if (an !== an_prev) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL disp_unexpected got an=%b seg=%b dp=%b want none",
                                 an, seg, dp_out);
                    end else begin
                        e = exp_q.pop_front();
                        if (({an, seg, dp_out} !== {e.an, e.seg, e.dp}) ||
                            (frames != int'(e.frame))) begin
                            errors++;
                            $display("FAIL disp got an=%b seg=%b dp=%b frames=%0d want an=%b seg=%b dp=%b frames=%0d",
                                     an, seg, dp_out, frames, e.an, e.seg, e.dp, e.frame);
                        end
                    end
                    frames = 0;
                end
            end
            an_prev = an;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        // Reset and release
        repeat (5) @(negedge clk);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp_out), 32'h1);
        chk("rst_ft", 32'(frame_tick), 32'h0);
        chk("rst_an_h", 32'(an_h), 32'h0);
        chk("rst_seg_h", 32'(seg_h), 32'h0);
        expect_disp(4'b1110, 7'b1000000, 1'b1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_an", 32'(an), 32'hE);
        chk("rel_seg", 32'(seg), 32'h40);
        repeat (5) @(negedge clk);
        chk("rel_hold_an", 32'(an), 32'hE);

        // Tick latency and level-insensitivity
        expect_disp(4'b1101, 7'b1000000, 1'b1, 1'b0);
        clk_div = 1'b1;
        repeat (4) @(negedge clk);
        chk("tick_t3_an", 32'(an), 32'hE);
        @(negedge clk);
        chk("tick_t4_an", 32'(an), 32'hD);
        repeat (96) @(negedge clk);
        chk("tick_held_an", 32'(an), 32'hD);
        clk_div = 1'b0;
        repeat (4) @(negedge clk);

        // Frame snapshot
        value = 16'h1A2F;
        step(4'b1011, 7'b1000000, 1'b1, 1'b0);
        step(4'b0111, 7'b1000000, 1'b1, 1'b0);
        step(4'b1110, 7'b0001110, 1'b1, 1'b1);
        step(4'b1101, 7'b0100100, 1'b1, 1'b0);
        value = 16'h0000;
        step(4'b1011, 7'b0001000, 1'b1, 1'b0);
        step(4'b0111, 7'b1111001, 1'b1, 1'b0);
        step(4'b1110, 7'b1000000, 1'b1, 1'b1);

        // Leading-zero blanking
        value    = 16'h0050;
        blank_en = 1'b1;
        step(4'b1101, 7'b1111111, 1'b1, 1'b0);
        step(4'b1011, 7'b1111111, 1'b1, 1'b0);
        step(4'b0111, 7'b1111111, 1'b1, 1'b0);
        step(4'b1110, 7'b1000000, 1'b1, 1'b1);
        step(4'b1101, 7'b0010010, 1'b1, 1'b0);
        step(4'b1011, 7'b1111111, 1'b1, 1'b0);
        step(4'b0111, 7'b1111111, 1'b1, 1'b0);
        dp_in = 4'b1000;
        step(4'b1110, 7'b1000000, 1'b1, 1'b1);
        step(4'b1101, 7'b0010010, 1'b1, 1'b0);
        step(4'b1011, 7'b1000000, 1'b1, 1'b0);
        step(4'b0111, 7'b1000000, 1'b0, 1'b0);

        // Active-high instance showing 8 on digit 0
        value    = 16'h0008;
        dp_in    = 4'b0000;
        blank_en = 1'b0;
        step(4'b1110, 7'b0000000, 1'b1, 1'b1);
        chk("hi_an", 32'(an_h), 32'h1);
        chk("hi_seg", 32'(seg_h), 32'h7F);
        chk("hi_dp", 32'(dp_h), 32'h0);

        // Mid-frame reset with clk_div high through release
        step(4'b1101, 7'b1000000, 1'b1, 1'b0);
        step(4'b1011, 7'b1000000, 1'b1, 1'b0);
        @(negedge clk);
        clk_div = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_an", 32'(an), 32'hF);
        expect_disp(4'b1110, 7'b1000000, 1'b1, 1'b0);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        chk("mid_post_an", 32'(an), 32'hE);
        chk("mid_post_seg", 32'(seg), 32'h40);
        chk("mid_post_dp", 32'(dp_out), 32'h1);
        clk_div = 1'b0;
        repeat (6) @(negedge clk);

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
